// File: rtl/psram_pkg.sv
// Shared definitions for the QPI PSRAM responder: FSM states, opcodes and address framing.
package psram_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SPI_CMD,
        ST_Q_CMD_HI,
        ST_Q_CMD_LO,
        ST_ADDR,
        ST_RD_WAIT,
        ST_RD_HI,
        ST_RD_LO,
        ST_WR_HI,
        ST_WR_LO,
        ST_IGNORE
    } resp_state_t;

    localparam logic [7:0] CMD_QPI_ENTER  = 8'h35;
    localparam logic [7:0] CMD_QPI_EXIT   = 8'hF5;
    localparam logic [7:0] CMD_QUAD_READ  = 8'hEB;
    localparam logic [7:0] CMD_QUAD_WRITE = 8'h38;

    localparam int ADDR_NIBBLES = 6;

endpackage

// File: rtl/psram_qpi_responder_if.sv
// Pad-side PSRAM bus as seen by the responder; master is the initiator/pad side.
interface psram_qpi_responder_if;
    import psram_pkg::*;

    // No valid/ready here: csn low frames a transaction and every sampled edge carries one beat.
    logic        i_psram_csn;
    logic [7:0]  i_psram_data;
    logic [7:0]  o_psram_data;
    logic [7:0]  o_psram_oe;
    logic        o_qpi_mode;
    logic        o_err;
    resp_state_t dbg_state;

    modport master (
        output i_psram_csn, i_psram_data,
        input  o_psram_data, o_psram_oe, o_qpi_mode, o_err, dbg_state
    );

    modport slave (
        input  i_psram_csn, i_psram_data,
        output o_psram_data, o_psram_oe, o_qpi_mode, o_err, dbg_state
    );

endinterface

// File: rtl/psram_lutram.sv
// Single-port 16-bit word store: synchronous write, asynchronous read (LUTRAM friendly).
module psram_lutram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata
);

    logic [15:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/psram_qpi_responder.sv
// PSRAM target emulator: SPI 0x35 QPI entry, 0xEB quad read, 0x38 quad write, 0xF5 exit.
// Define PSRAM_RESPONDER_NIBBLE_CHECK_EN to enable the sticky chip-A/chip-B lane comparator.
module psram_qpi_responder
    import psram_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int READ_WAIT = 5
) (
    input logic                  i_clk,
    input logic                  arst,
    psram_qpi_responder_if.slave bus
);

    localparam logic [3:0] WAIT_LAST = 4'(READ_WAIT - 2);
    localparam logic [3:0] ADDR_LAST = 4'(ADDR_NIBBLES - 1);

    resp_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        cmd_q, cmd_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        oe_q, oe_d;
    logic              qpi_q, qpi_d;
    logic              mem_we;
    logic [15:0]       mem_rdata;

    logic       csn;
    logic [7:0] din;
    assign csn = bus.i_psram_csn;
    assign din = bus.i_psram_data;

    psram_lutram #(.ADDR_W(ADDR_W)) u_mem (
        .clk   (i_clk),
        .we    (mem_we),
        .addr  (ptr_q),
        .wdata ({hi_q, din}),
        .rdata (mem_rdata)
    );

    always_ff @(posedge i_clk or posedge arst) begin
        if (arst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            ptr_q       <= '0;
            hi_q        <= '0;
            data_q      <= '0;
            oe_q        <= '0;
            qpi_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            ptr_q       <= ptr_d;
            hi_q        <= hi_d;
            data_q      <= data_d;
            oe_q        <= oe_d;
            qpi_q       <= qpi_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        ptr_d       = ptr_q;
        hi_d        = hi_q;
        data_d      = data_q;
        oe_d        = 8'h00;
        qpi_d       = qpi_q;
        mem_we      = 1'b0;

        if (csn) begin
            // Mode changes take effect only when a complete opcode is framed by csn.
            state_d     = ST_IDLE;
            cnt_d       = '0;
            cmd_valid_d = 1'b0;
            if (cmd_valid_q && !qpi_q && cmd_q == CMD_QPI_ENTER) qpi_d = 1'b1;
            if (cmd_valid_q &&  qpi_q && cmd_q == CMD_QPI_EXIT)  qpi_d = 1'b0;
        end else begin
            case (state_q)
                // IDLE consumes edge k=0 itself, so the QPI high-nibble phase is folded in here.
                ST_IDLE: begin
                    if (qpi_q) begin
                        cmd_d   = {din[3:0], 4'h0};
                        state_d = ST_Q_CMD_LO;
                    end else begin
                        cmd_d   = {7'h00, din[0]};
                        cnt_d   = 4'd1;
                        state_d = ST_SPI_CMD;
                    end
                end
                ST_SPI_CMD: begin
                    cmd_d = {cmd_q[6:0], din[0]};
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cmd_valid_d = 1'b1;
                        state_d     = ST_IGNORE;
                    end
                end
                ST_Q_CMD_LO: begin
                    cmd_d       = {cmd_q[7:4], din[3:0]};
                    cmd_valid_d = 1'b1;
                    cnt_d       = '0;
                    if (cmd_d == CMD_QUAD_READ || cmd_d == CMD_QUAD_WRITE) state_d = ST_ADDR;
                    else                                                   state_d = ST_IGNORE;
                end
                ST_ADDR: begin
                    // Shifting through an ADDR_W-wide pointer keeps only the low address bits.
                    ptr_d = ADDR_W'({ptr_q, din[3:0]});
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d = '0;
                        if (cmd_q == CMD_QUAD_READ) state_d = (READ_WAIT > 1) ? ST_RD_WAIT : ST_RD_HI;
                        else                        state_d = ST_WR_HI;
                    end
                end
                ST_RD_WAIT: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == WAIT_LAST) state_d = ST_RD_HI;
                end
                ST_RD_HI: begin
                    data_d  = mem_rdata[15:8];
                    oe_d    = 8'hFF;
                    state_d = ST_RD_LO;
                end
                ST_RD_LO: begin
                    data_d  = mem_rdata[7:0];
                    oe_d    = 8'hFF;
                    ptr_d   = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    state_d = ST_RD_HI;
                end
                ST_WR_HI: begin
                    hi_d    = din;
                    state_d = ST_WR_LO;
                end
                ST_WR_LO: begin
                    mem_we  = 1'b1;
                    ptr_d   = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    state_d = ST_WR_HI;
                end
                default: ;
            endcase
        end
    end

`ifdef PSRAM_RESPONDER_NIBBLE_CHECK_EN
    logic [3:0] k_q;
    logic       err_q;
    logic       lane_mismatch;

    // Both chips must see identical command/address lanes during the header edges.
    assign lane_mismatch = qpi_q ? (din[7:4] != din[3:0]) : (din[4] != din[0]);

    always_ff @(posedge i_clk or posedge arst) begin
        if (arst) begin
            k_q   <= '0;
            err_q <= 1'b0;
        end else if (csn) begin
            k_q <= '0;
        end else if (k_q < 4'd8) begin
            k_q <= k_q + 4'd1;
            if (lane_mismatch) err_q <= 1'b1;
        end
    end

    assign bus.o_err = err_q;
`else
    assign bus.o_err = 1'b0;
`endif

    assign bus.o_psram_data = data_q;
    assign bus.o_psram_oe   = oe_q;
    assign bus.o_qpi_mode   = qpi_q;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_psram_qpi_responder.sv
// Directed + randomized bench for psram_qpi_responder against a word-array reference model.
module tb_psram_qpi_responder;

  localparam int ADDR_W    = 8;
  localparam int READ_WAIT = 5;
  localparam int DEPTH     = 2 ** ADDR_W;

  // clock / reset
  logic i_clk = 1'b0;
  logic arst;
  always #5 i_clk = ~i_clk;

  psram_qpi_responder_if bus();

  psram_qpi_responder #(.ADDR_W(ADDR_W), .READ_WAIT(READ_WAIT)) dut (
    .i_clk (i_clk),
    .arst  (arst),
    .bus   (bus)
  );

  // reference model and scoreboard
  int checks = 0;
  int errors = 0;
  logic [15:0] ref_mem [DEPTH];
  bit          ref_qpi;
  bit          ref_err;
  logic [15:0] exp_q[$];
  logic [15:0] wr_data[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: drive, take one rising edge, sample 1ns later
  task automatic step(input logic csn, input logic [7:0] d);
    bus.i_psram_csn  = csn;
    bus.i_psram_data = d;
    @(posedge i_clk);
    #1;
  endtask

  task automatic end_txn();
    step(1'b1, 8'h00);
    chk("idle_oe", bus.o_psram_oe, 16'h0);
    chk("qpi_mode", bus.o_qpi_mode, 16'(ref_qpi));
    chk("err", bus.o_err, 16'(ref_err));
  endtask

  task automatic spi_cmd(input logic [7:0] c);
    for (int i = 0; i < 8; i++) begin
      logic b;
      b = c[7-i];
      step(1'b0, {3'b000, b, 3'b000, b});
      chk("spi_oe", bus.o_psram_oe, 16'h0);
    end
    if (!ref_qpi && c == 8'h35) ref_qpi = 1'b1;
    end_txn();
  endtask

  task automatic qpi_head(input logic [7:0] c, input logic [23:0] a);
    logic [31:0] s;
    s = {c, a};
    for (int i = 0; i < 8; i++) begin
      logic [3:0] n;
      n = s[31-4*i -: 4];
      step(1'b0, {n, n});
      chk("hdr_oe", bus.o_psram_oe, 16'h0);
    end
  endtask

  task automatic qpi_cmd_only(input logic [7:0] c);
    step(1'b0, {c[7:4], c[7:4]});
    step(1'b0, {c[3:0], c[3:0]});
    if (ref_qpi && c == 8'hF5) ref_qpi = 1'b0;
    end_txn();
  endtask

  task automatic qpi_write(input logic [23:0] a);
    qpi_head(8'h38, a);
    for (int i = 0; i < wr_data.size(); i++) begin
      step(1'b0, wr_data[i][15:8]);
      chk("wr_oe_hi", bus.o_psram_oe, 16'h0);
      step(1'b0, wr_data[i][7:0]);
      chk("wr_oe_lo", bus.o_psram_oe, 16'h0);
      ref_mem[(int'(a) + i) % DEPTH] = wr_data[i];
    end
    end_txn();
  endtask

  task automatic qpi_read(input logic [23:0] a, input int n);
    logic [15:0] w;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[(int'(a) + i) % DEPTH]);
    qpi_head(8'hEB, a);
    for (int k = 8; k < 7 + READ_WAIT; k++) begin
      step(1'b0, 8'($urandom));
      chk("rd_wait_oe", bus.o_psram_oe, 16'h0);
    end
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      step(1'b0, 8'($urandom));
      chk("rd_oe_hi", bus.o_psram_oe, 16'hFF);
      chk("rd_data_hi", bus.o_psram_data, 16'(w[15:8]));
      step(1'b0, 8'($urandom));
      chk("rd_oe_lo", bus.o_psram_oe, 16'hFF);
      chk("rd_data_lo", bus.o_psram_data, 16'(w[7:0]));
    end
    end_txn();
  endtask

  initial begin
    ref_qpi = 1'b0;
    ref_err = 1'b0;
    arst = 1'b1;
    bus.i_psram_csn  = 1'b1;
    bus.i_psram_data = 8'h00;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_data", bus.o_psram_data, 16'h0);
    chk("rst_oe", bus.o_psram_oe, 16'h0);
    chk("rst_qpi", bus.o_qpi_mode, 16'h0);
    chk("rst_err", bus.o_err, 16'h0);
    arst = 1'b0;
    step(1'b1, 8'h00);

    // SPI entry, then the basic write/read pair
    spi_cmd(8'h35);
    wr_data = '{16'hA55A};
    qpi_write(24'h000012);
    qpi_read(24'h000012, 1);

    // burst write wrapping past the top of the array
    wr_data = '{16'h1111, 16'h2222};
    qpi_write(24'h0000FF);
    qpi_read(24'h0000FF, 2);
    qpi_read(24'h000000, 1);

    // aborted write after the high byte leaves memory alone
    wr_data = '{16'h0F0F};
    qpi_write(24'h000005);
    qpi_head(8'h38, 24'h000005);
    step(1'b0, 8'hC3);
    end_txn();
    qpi_read(24'h000005, 1);

    // upper address bits ignored
    wr_data = '{16'hABCD};
    qpi_write(24'h7F0033);
    qpi_read(24'h000033, 1);

    // unknown QPI command is ignored
    qpi_head(8'h9F, 24'h000012);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'($urandom));
      chk("ign_oe", bus.o_psram_oe, 16'h0);
    end
    end_txn();

    // randomized write bursts read back in random sub-ranges
    for (int it = 0; it < 20; it++) begin
      logic [23:0] a;
      int n, off, len;
      a = 24'($urandom);
      n = $urandom_range(1, 4);
      wr_data.delete();
      for (int i = 0; i < n; i++) wr_data.push_back(16'($urandom));
      qpi_write(a);
      off = $urandom_range(0, n - 1);
      len = $urandom_range(1, n - off);
      qpi_read(a + 24'(off), len);
    end

    // QPI exit, non-entry SPI command ignored, re-entry
    qpi_cmd_only(8'hF5);
    spi_cmd(8'h9F);
    spi_cmd(8'h35);

    // asynchronous reset in the middle of a read burst
    qpi_head(8'hEB, 24'h000012);
    for (int k = 8; k <= 7 + READ_WAIT; k++) step(1'b0, 8'h00);
    chk("pre_rst_oe", bus.o_psram_oe, 16'hFF);
    #2 arst = 1'b1;
    #1;
    chk("mid_rst_data", bus.o_psram_data, 16'h0);
    chk("mid_rst_oe", bus.o_psram_oe, 16'h0);
    chk("mid_rst_qpi", bus.o_qpi_mode, 16'h0);
    ref_qpi = 1'b0;
    ref_err = 1'b0;
    bus.i_psram_csn = 1'b1;
    @(posedge i_clk);
    #1 arst = 1'b0;
    step(1'b1, 8'h00);
    spi_cmd(8'h35);
    qpi_read(24'h000012, 1);

`ifdef PSRAM_RESPONDER_NIBBLE_CHECK_EN
    // mismatched chip lanes in the command phase latch the error flag
    step(1'b0, {4'h6, 4'hE});
    step(1'b0, {4'hB, 4'hB});
    ref_err = 1'b1;
    end_txn();
    wr_data = '{16'h5AA5};
    qpi_write(24'h000040);
    qpi_read(24'h000040, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psram_qpi_responder.md
# psram_qpi_responder

On-chip PSRAM target emulator for the LUTRAM stress test, backed by a LUTRAM word array. It sits on the far side of the dual-chip QPI PSRAM bus and answers the existing PSRAM initiator cycle-for-cycle:
- SPI-mode 0x35 entry into QPI mode
- QPI 0xEB quad read with 5 wait edges
- QPI 0x38 quad write

The bus runs on the initiator's own clock. This lets the controller be loop-tested without external chips.

## Interface
- `ADDR_W`, default 8: number of address LSBs used as the word index; array depth is 2^ADDR_W × 16 bits.
- `READ_WAIT`, default 5: edges between the last address nibble and the launch of the read high byte.
- `i_clk` (in, 1): the only clock; same clock the initiator drives SCLK from.
- `arst` (in, 1): asynchronous, active-high reset.
- `i_psram_csn` (in, 1): chip select, active low.
- `i_psram_data` (in, 8): bus sampled from the pads; lines [3:0] are chip A, [7:4] are chip B.
- `o_psram_data` (out, 8): responder drive value.
- `o_psram_oe` (out, 8): per-line drive enable; the pad wrapper builds the tristate.
- `o_qpi_mode` (out, 1): high once a valid 0x35 has been received.
- `o_err` (out, 1): sticky protocol error flag (see Configuration).

## Operation
- Edge index k counts `i_clk` rising edges that sample `i_psram_csn`=0, starting at 0.
- An edge sampling csn=1 does all of the following, from any state:
  - returns to IDLE
  - clears `o_psram_oe`
  - discards any partial word
- SPI mode (`o_qpi_mode`=0):
  - Edges k=0..7 shift `i_psram_data[0]` MSB-first into an 8-bit command.
  - If that command equals 0x35, `o_qpi_mode` is set on the csn-high edge.
  - Any other command is ignored.
  - Edges with k>7 are ignored.
- QPI mode, command phase: k=0 gives cmd[7:4] and k=1 gives cmd[3:0], both taken from lines [3:0].
- QPI mode, address phase: k=2..7 give addr[23:0], nibble-wise MSB first, from lines [3:0].
- The word pointer is addr[ADDR_W-1:0]. Upper address bits are ignored.
- Read (0xEB):
  - k=8..6+READ_WAIT: wait; `o_psram_oe`=0.
  - k=7+READ_WAIT: drive mem[ptr][15:8] with `o_psram_oe`=0xFF.
  - Next edge: drive mem[ptr][7:0] and increment ptr.
  - This continues as a burst, alternating high byte then low byte, until csn rises.
- Write (0x38):
  - k=8: capture `i_psram_data` as the high byte.
  - k=9: capture the low byte, write {hi,lo} to mem[ptr], increment ptr.
  - Further byte pairs burst-write in the same way.
- Any other QPI command: IGNORE state until csn rises.
- In QPI mode, 0xF5 clears `o_qpi_mode` on the csn-high edge (exit QPI).
- The pointer wraps modulo 2^ADDR_W.
- State list: IDLE, SPI_CMD, Q_CMD_HI, Q_CMD_LO, ADDR (3-bit count 0..5), RD_WAIT (4-bit count), RD_HI, RD_LO, WR_HI, WR_LO, IGNORE.

## Timing
- Reset values:
  - `o_psram_data`=0, `o_psram_oe`=0
  - `o_qpi_mode`=0, `o_err`=0
  - state IDLE, ptr 0
  - Memory contents are not reset.
- All outputs are registered. Data launched at edge k is sampled by the initiator at edge k+1.
- With `READ_WAIT`=5, the high byte is launched at k=12 and the low byte at k=13. This matches initiator capture at k=13 and k=14.
- `o_psram_oe` stays 0 through k=11. This guarantees one full idle edge after the initiator releases the bus at k=7.
- A write commits to memory on the k=9 edge. A read issued in the next transaction returns the new data.
- csn rising after only the high byte of a write: no memory update.
- Reset mid-transaction: outputs drop to reset values immediately.

## Configuration
- `PSRAM_RESPONDER_NIBBLE_CHECK_EN` defined:
  - During k=0..7 in QPI mode, `i_psram_data[7:4]` is compared against `[3:0]`.
  - During k=0..7 in SPI mode, line 4 is compared against line 0.
  - Any mismatch sets `o_err`, which stays set until reset.
- Not defined: `o_err` is tied to 0 and the comparator is absent.

## Structure
- Shared package `psram_pkg`:
  - responder state enum
  - command constants: `CMD_QPI_ENTER`=0x35, `CMD_QPI_EXIT`=0xF5, `CMD_QUAD_READ`=0xEB, `CMD_QUAD_WRITE`=0x38
  - the address nibble count constant, 6
- Sub-module `psram_lutram`: single-port, 16-bit wide, 2^ADDR_W deep; synchronous write, asynchronous read, so it maps to LUTRAM.

## Test plan
- After reset, SPI 0x35 on lines 0/4 over 8 edges, then csn high -> `o_qpi_mode`=1; `o_err`=0.
- QPI write to address 0x000012 with data 0xA55A -> mem[0x12]=0xA55A after k=9; no `o_psram_oe` asserted during the write.
- QPI read of 0x000012 -> `o_psram_data`=0xA5 at k=12 and 0x5A at k=13, with `o_psram_oe`=0xFF only from k=12; the existing initiator returns `o_dout`=0xA55A.
- Burst write of 0x1111, 0x2222 at 0x0000FF (ADDR_W=8) -> mem[0xFF]=0x1111, mem[0x00]=0x2222 (wrap).
- csn high after the high byte of a write to 0x05 -> mem[0x05] unchanged; next transaction decodes normally.
- With the macro defined: a command phase whose nibbles differ (0xE on [3:0], 0x6 on [7:4]) -> `o_err`=1, and it holds through later valid transactions.
